// File: rtl/cpu_run_sequencer_if.sv
// Control and loader bus between the run sequencer and its surroundings
// (UART loader/sender, instruction memory, CPU pipeline, status).
interface cpu_run_sequencer_if;
    logic        start;
    logic        uart_wr_en;
    logic [15:0] uart_addr;
    logic [31:0] uart_wdata;
    logic        recv_done;
    logic        send_done;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        imem_wr_en;
    logic [15:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        cpu_hold;
    logic        dump_req;
    logic [2:0]  state;
    logic [15:0] words_loaded;
    logic [31:0] run_cycles;
    logic        done;
    logic        fault;

    // Environment side: drives commands, loader traffic and pipeline view.
    modport master (
        output start, uart_wr_en, uart_addr, uart_wdata, recv_done, send_done,
               id_inst, id_valid,
        input  imem_wr_en, imem_addr, imem_wdata, cpu_reset, cpu_hold, dump_req,
               state, words_loaded, run_cycles, done, fault
    );

    // Sequencer side.
    modport slave (
        input  start, uart_wr_en, uart_addr, uart_wdata, recv_done, send_done,
               id_inst, id_valid,
        output imem_wr_en, imem_addr, imem_wdata, cpu_reset, cpu_hold, dump_req,
               state, words_loaded, run_cycles, done, fault
    );
endinterface

// File: rtl/cpu_run_sequencer.sv
// Run controller for the pipelined CPU: load over UART, run, drain the
// pipeline after a halt instruction, then trigger the UART result dump.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start, CPU held in reset
//   LOAD   | UART writes pass through to instruction memory
//   RUN    | CPU released, watching IF/ID for the halt instruction
//   DRAIN  | CPU frozen while EX, MEM and WB retire
//   DUMP   | result dump requested, waiting for the sender to finish
//   DONE   | program finished and results sent
//   FAULT  | empty load or watchdog expiry
module cpu_run_sequencer #(
    parameter logic [31:0] HALT_INST      = 32'hFC00_0000,
    parameter int unsigned DRAIN_CYCLES   = 3,
    parameter logic [31:0] MAX_RUN_CYCLES = 32'd50_000_000
) (
    input logic                 clk,
    input logic                 reset,
    cpu_run_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DUMP  = 3'd4,
        DONE  = 3'd5,
        FAULT = 3'd6
    } state_t;

    // Down-counter reload: terminal count 0 is the last DRAIN cycle.
    localparam logic [7:0] DRAIN_RELOAD = 8'(DRAIN_CYCLES - 1);

    state_t      state_q, state_d;
    logic        recv_prev, send_prev;
    logic        recv_rise, send_rise;
    logic        halt_seen;
    logic        cpu_reset;
    logic [7:0]  drain_cnt;
    logic [15:0] words_loaded;
    logic [31:0] run_cycles;
    logic        done_q, fault_q, dump_req_q;

    assign recv_rise = bus.recv_done & ~recv_prev;
    assign send_rise = bus.send_done & ~send_prev;
    assign cpu_reset = !(state_q == RUN || state_q == DRAIN);
    assign halt_seen = (bus.id_inst == HALT_INST) && bus.id_valid && !cpu_reset;

    assign bus.imem_wr_en   = bus.uart_wr_en && (state_q == LOAD);
    assign bus.imem_addr    = bus.uart_addr;
    assign bus.imem_wdata   = bus.uart_wdata;
    assign bus.cpu_reset    = cpu_reset;
    assign bus.cpu_hold     = (state_q == DRAIN) || (state_q == DUMP) || (state_q == DONE);
    assign bus.dump_req     = dump_req_q;
    assign bus.state        = state_q;
    assign bus.words_loaded = words_loaded;
    assign bus.run_cycles   = run_cycles;
    assign bus.done         = done_q;
    assign bus.fault        = fault_q;

    // State register, edge-detect history and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            recv_prev  <= 1'b0;
            send_prev  <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            dump_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            recv_prev  <= bus.recv_done;
            send_prev  <= bus.send_done;
            done_q     <= (state_d == DONE);
            fault_q    <= (state_d == FAULT);
            dump_req_q <= (state_d == DUMP) && (state_q != DUMP);
        end
    end

    // Next-state decode; halt wins over the watchdog in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, FAULT: if (bus.start) state_d = LOAD;
            LOAD:  if (recv_rise) state_d = (words_loaded != 16'd0) ? RUN : FAULT;
            RUN: begin
                if (halt_seen)                              state_d = DRAIN;
                else if (run_cycles == MAX_RUN_CYCLES - 1) state_d = FAULT;
            end
            DRAIN: if (drain_cnt == 8'd0) state_d = DUMP;
            DUMP:  if (send_rise) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Load word count, run-cycle count and drain down-counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            words_loaded <= 16'd0;
            run_cycles   <= 32'd0;
            drain_cnt    <= 8'd0;
        end else if (state_d == LOAD && state_q != LOAD) begin
            words_loaded <= 16'd0;
            run_cycles   <= 32'd0;
            drain_cnt    <= 8'd0;
        end else begin
            if (state_q == LOAD && bus.uart_wr_en && words_loaded != 16'hFFFF)
                words_loaded <= words_loaded + 16'd1;
            if (state_q == RUN)
                run_cycles <= run_cycles + 32'd1;
            if (state_d == DRAIN && state_q != DRAIN)
                drain_cnt <= DRAIN_RELOAD;
            else if (state_q == DRAIN && drain_cnt != 8'd0)
                drain_cnt <= drain_cnt - 8'd1;
        end
    end
endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Directed bench for cpu_run_sequencer, watchdog shortened to 20 RUN cycles.
module tb_cpu_run_sequencer;
    localparam logic [31:0] HALT = 32'hFC00_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    cpu_run_sequencer_if bus ();

    cpu_run_sequencer #(
        .HALT_INST      (HALT),
        .DRAIN_CYCLES   (3),
        .MAX_RUN_CYCLES (32'd20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", bus.state); end
        checks++; if ({bus.cpu_reset, bus.cpu_hold, bus.dump_req, bus.done, bus.fault} !== 5'b10000) begin
            errors++; $display("FAIL reset_flags got %b exp 10000", {bus.cpu_reset, bus.cpu_hold, bus.dump_req, bus.done, bus.fault}); end
        checks++; if (bus.words_loaded !== 16'd0 || bus.run_cycles !== 32'd0) begin
            errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", bus.words_loaded, bus.run_cycles); end
    endtask

    task automatic test_stray_idle();
        bus.uart_wr_en = 1'b1; bus.uart_addr = 16'h0055; bus.uart_wdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (bus.imem_wr_en !== 1'b0) begin errors++; $display("FAIL idle_wr_en got %b exp 0", bus.imem_wr_en); end
        tick();
        bus.uart_wr_en = 1'b0;
        checks++; if (bus.words_loaded !== 16'd0) begin errors++; $display("FAIL idle_words got %0d exp 0", bus.words_loaded); end
    endtask

    // Four writes, recv_done rise, then stray traffic and a halt at RUN cycle 10.
    task automatic test_normal_load_and_halt();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL load_entry got %0d exp 1", bus.state); end
        for (int i = 0; i < 4; i++) begin
            bus.uart_wr_en = 1'b1; bus.uart_addr = 16'(i); bus.uart_wdata = 32'h1000_0000 + 32'(i);
            #1;
            checks++; if ({bus.imem_wr_en, bus.imem_addr, bus.imem_wdata} !== {1'b1, 16'(i), 32'h1000_0000 + 32'(i)}) begin
                errors++; $display("FAIL load_pass%0d got %b/%h/%h", i, bus.imem_wr_en, bus.imem_addr, bus.imem_wdata); end
            tick();
        end
        bus.uart_wr_en = 1'b0;
        checks++; if (bus.words_loaded !== 16'd4) begin errors++; $display("FAIL load_words got %0d exp 4", bus.words_loaded); end
        bus.recv_done = 1'b1;
        tick();
        checks++; if (bus.state !== 3'd2 || bus.cpu_reset !== 1'b0) begin
            errors++; $display("FAIL run_entry got state %0d rst %b exp 2/0", bus.state, bus.cpu_reset); end
        // RUN cycle 1: stray write and start.
        bus.recv_done = 1'b0;
        bus.uart_wr_en = 1'b1; bus.start = 1'b1;
        #1;
        checks++; if (bus.imem_wr_en !== 1'b0) begin errors++; $display("FAIL run_wr_en got %b exp 0", bus.imem_wr_en); end
        tick();
        bus.uart_wr_en = 1'b0; bus.start = 1'b0;
        checks++; if (bus.state !== 3'd2 || bus.words_loaded !== 16'd4) begin
            errors++; $display("FAIL run_stray got state %0d words %0d exp 2/4", bus.state, bus.words_loaded); end
        // RUN cycle 2: halt encoding but not valid.
        bus.id_inst = HALT; bus.id_valid = 1'b0;
        tick();
        checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL invalid_halt got %0d exp 2", bus.state); end
        bus.id_inst = NOP; bus.id_valid = 1'b1;
        for (int i = 3; i < 10; i++) tick();
        // RUN cycle 10 carries the halt.
        bus.id_inst = HALT; bus.id_valid = 1'b1;
        tick();
        bus.id_inst = NOP;
        checks++; if (bus.state !== 3'd3 || bus.run_cycles !== 32'd10) begin
            errors++; $display("FAIL halt_drain got state %0d run %0d exp 3/10", bus.state, bus.run_cycles); end
        checks++; if (bus.cpu_hold !== 1'b1 || bus.cpu_reset !== 1'b0 || bus.dump_req !== 1'b0) begin
            errors++; $display("FAIL drain_flags got hold %b rst %b req %b exp 1/0/0", bus.cpu_hold, bus.cpu_reset, bus.dump_req); end
        tick();
        tick();
        checks++; if (bus.state !== 3'd3 || bus.dump_req !== 1'b0) begin
            errors++; $display("FAIL drain_len got state %0d req %b exp 3/0", bus.state, bus.dump_req); end
        tick();
        checks++; if (bus.state !== 3'd4 || bus.dump_req !== 1'b1 || bus.cpu_reset !== 1'b1) begin
            errors++; $display("FAIL dump_entry got state %0d req %b rst %b exp 4/1/1", bus.state, bus.dump_req, bus.cpu_reset); end
        tick();
        checks++; if (bus.state !== 3'd4 || bus.dump_req !== 1'b0) begin
            errors++; $display("FAIL dump_pulse got state %0d req %b exp 4/0", bus.state, bus.dump_req); end
        bus.send_done = 1'b1;
        tick();
        bus.send_done = 1'b0;
        checks++; if ({bus.state, bus.done, bus.fault, bus.cpu_hold, bus.cpu_reset} !== {3'd5, 4'b1011}) begin
            errors++; $display("FAIL done got %0d %b%b%b%b exp 5 1011", bus.state, bus.done, bus.fault, bus.cpu_hold, bus.cpu_reset); end
    endtask

    // Empty load faults; a recv_done level already high on LOAD entry is not a rise.
    task automatic test_empty_load();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if ({bus.state, bus.done, bus.words_loaded, bus.run_cycles} !== {3'd1, 1'b0, 16'd0, 32'd0}) begin
            errors++; $display("FAIL reload_clear got state %0d done %b words %0d run %0d", bus.state, bus.done, bus.words_loaded, bus.run_cycles); end
        bus.recv_done = 1'b1;
        tick();
        checks++; if (bus.state !== 3'd6 || bus.fault !== 1'b1 || bus.cpu_reset !== 1'b1) begin
            errors++; $display("FAIL empty_fault got state %0d fault %b rst %b exp 6/1/1", bus.state, bus.fault, bus.cpu_reset); end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        checks++; if (bus.state !== 3'd1 || bus.fault !== 1'b0) begin
            errors++; $display("FAIL level_not_rise got state %0d fault %b exp 1/0", bus.state, bus.fault); end
        bus.recv_done = 1'b0;
        tick();
    endtask

    // From LOAD: one write, then a write coincident with the recv_done rise.
    task automatic load_two_and_run(input string tag);
        bus.uart_wr_en = 1'b1;
        tick();
        bus.recv_done = 1'b1;
        tick();
        bus.uart_wr_en = 1'b0; bus.recv_done = 1'b0;
        checks++; if (bus.state !== 3'd2 || bus.words_loaded !== 16'd2) begin
            errors++; $display("FAIL %s_run got state %0d words %0d exp 2/2", tag, bus.state, bus.words_loaded); end
    endtask

    task automatic test_watchdog();
        load_two_and_run("wdog");
        bus.id_inst = HALT; bus.id_valid = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        checks++; if (bus.state !== 3'd2 || bus.run_cycles !== 32'd19) begin
            errors++; $display("FAIL wdog_pre got state %0d run %0d exp 2/19", bus.state, bus.run_cycles); end
        tick();
        checks++; if (bus.state !== 3'd6 || bus.fault !== 1'b1 || bus.run_cycles !== 32'd20) begin
            errors++; $display("FAIL wdog_fire got state %0d fault %b run %0d exp 6/1/20", bus.state, bus.fault, bus.run_cycles); end
        bus.id_inst = NOP;
    endtask

    task automatic test_halt_vs_watchdog();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        load_two_and_run("prio");
        for (int i = 0; i < 19; i++) tick();
        bus.id_inst = HALT; bus.id_valid = 1'b1;
        tick();
        bus.id_inst = NOP;
        checks++; if (bus.state !== 3'd3 || bus.fault !== 1'b0 || bus.run_cycles !== 32'd20) begin
            errors++; $display("FAIL prio_drain got state %0d fault %b run %0d exp 3/0/20", bus.state, bus.fault, bus.run_cycles); end
    endtask

    task automatic test_mid_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({bus.state, bus.cpu_reset, bus.cpu_hold, bus.dump_req, bus.done, bus.fault} !== {3'd0, 5'b10000}
                      || bus.words_loaded !== 16'd0 || bus.run_cycles !== 32'd0) begin
            errors++; $display("FAIL drain_reset got state %0d words %0d run %0d", bus.state, bus.words_loaded, bus.run_cycles); end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        load_two_and_run("rst2");
        bus.id_inst = HALT; bus.id_valid = 1'b1;
        tick();
        bus.id_inst = NOP;
        tick(); tick(); tick();
        checks++; if (bus.state !== 3'd4 || bus.dump_req !== 1'b1) begin
            errors++; $display("FAIL rst2_dump got state %0d req %b exp 4/1", bus.state, bus.dump_req); end
        bus.send_done = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.send_done = 1'b0;
        checks++; if ({bus.state, bus.cpu_reset, bus.cpu_hold, bus.dump_req, bus.done, bus.fault} !== {3'd0, 5'b10000}
                      || bus.words_loaded !== 16'd0 || bus.run_cycles !== 32'd0) begin
            errors++; $display("FAIL dump_reset got state %0d hold %b req %b done %b", bus.state, bus.cpu_hold, bus.dump_req, bus.done); end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        load_two_and_run("clean");
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0;
        bus.start = 1'b0; bus.uart_wr_en = 1'b0; bus.uart_addr = 16'd0; bus.uart_wdata = 32'd0;
        bus.recv_done = 1'b0; bus.send_done = 1'b0; bus.id_inst = NOP; bus.id_valid = 1'b0;
        test_reset();
        test_stray_idle();
        test_normal_load_and_halt();
        test_empty_load();
        test_watchdog();
        test_halt_vs_watchdog();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
